// File: rtl/vec_regfile_mp_if.sv
// Bus bundle for vec_regfile_mp: read ports, writeback port, load port.
//   rd_en/rd_addr/rd_off    : flattened per-port read requests (port p at slice p)
//   rd_data/rd_hazard       : registered read data and pending-load hazard flags
//   wb_en/wb_addr/wb_off/wb_data : writeback beat, never stalls
//   ld_en/ld_addr/ld_off/ld_data : load beat, accepted when |ld_en && ld_ready
//   ld_ready/pend_count     : load backpressure and pending-buffer occupancy
interface vec_regfile_mp_if #(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_RD     = 3,
    parameter int unsigned PEND_DEPTH = 4
);
    localparam int unsigned DW_B     = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS = $clog2(VLEN / DATA_WIDTH);
    localparam int unsigned CNT_W    = $clog2(PEND_DEPTH + 1);

    logic [NUM_RD*DW_B-1:0]       rd_en;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*OFF_BITS-1:0]   rd_off;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_hazard;

    logic [DW_B-1:0]       wb_en;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [OFF_BITS-1:0]   wb_off;
    logic [DATA_WIDTH-1:0] wb_data;

    logic [DW_B-1:0]       ld_en;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [OFF_BITS-1:0]   ld_off;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_ready;
    logic [CNT_W-1:0]      pend_count;

    // Requester side (execution/load units)
    modport master (
        output rd_en, rd_addr, rd_off,
        input  rd_data, rd_hazard,
        output wb_en, wb_addr, wb_off, wb_data,
        output ld_en, ld_addr, ld_off, ld_data,
        input  ld_ready, pend_count
    );

    // Register file side
    modport slave (
        input  rd_en, rd_addr, rd_off,
        output rd_data, rd_hazard,
        input  wb_en, wb_addr, wb_off, wb_data,
        input  ld_en, ld_addr, ld_off, ld_data,
        output ld_ready, pend_count
    );
endinterface

// File: rtl/vec_regfile_mp.sv
// Multi-port vector register file with NUM_RD byte-enabled read ports, a
// never-stalling writeback port and a load port. Loads colliding with a
// same-cycle writeback are deferred into an in-order pending buffer.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (storage is not reset)
//   bus : vec_regfile_mp_if.slave, see interface for signal list
module vec_regfile_mp #(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_RD     = 3,
    parameter int unsigned PEND_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    vec_regfile_mp_if.slave bus
);
    localparam int unsigned DW_B     = DATA_WIDTH / 8;
    localparam int unsigned NBEAT    = VLEN / DATA_WIDTH;
    localparam int unsigned OFF_BITS = $clog2(NBEAT);
    localparam int unsigned NREG     = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W    = $clog2(PEND_DEPTH);
    localparam int unsigned CNT_W    = $clog2(PEND_DEPTH + 1);

    typedef logic [DW_B-1:0][7:0] beat_t;

    typedef struct packed {
        beat_t                 data;
        logic [DW_B-1:0]       en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [OFF_BITS-1:0]   off;
    } ld_beat_t;

    // Bytes are stored XORed with the register index byte, so the all-zero
    // power-up image reads back as c[7:0] in every byte of register c.
    beat_t mem [NREG][NBEAT];

    ld_beat_t              pend_q [PEND_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  ld_ready_q;
    logic [NUM_RD-1:0][DW_B-1:0][7:0] rd_data_q;
    logic [NUM_RD-1:0]     rd_hazard_q;

    function automatic logic collides(ld_beat_t b, logic [DW_B-1:0] en,
                                      logic [ADDR_WIDTH-1:0] addr, logic [OFF_BITS-1:0] off);
        return (b.addr == addr) && (b.off == off) && ((b.en & en) != '0);
    endfunction

    // Load path arbitration: pop the head when clear of wb, else commit direct
    ld_beat_t          ld_in, head, commit_beat;
    logic              ld_acc, do_pop, do_direct, do_push, ld_commit;
    logic [CNT_W-1:0]  count_next;

    always_comb begin
        ld_in       = {bus.ld_data, bus.ld_en, bus.ld_addr, bus.ld_off};
        head        = pend_q[rd_ptr_q];
        ld_acc      = (bus.ld_en != '0) && ld_ready_q;
        do_pop      = (count_q != '0) && !collides(head, bus.wb_en, bus.wb_addr, bus.wb_off);
        do_direct   = ld_acc && (count_q == '0)
                      && !collides(ld_in, bus.wb_en, bus.wb_addr, bus.wb_off);
        do_push     = ld_acc && !do_direct;
        ld_commit   = do_pop || do_direct;
        commit_beat = do_pop ? head : ld_in;
        count_next  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Per-port decoded read word and hazard against valid pending entries
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_word;
    logic [NUM_RD-1:0]                 hit;
    logic [ADDR_WIDTH-1:0]             ra;
    logic [OFF_BITS-1:0]               ro;
    logic [DW_B-1:0]                   re;
    logic [PTR_W-1:0]                  age;

    always_comb begin
        rd_word = '0;
        hit     = '0;
        ra      = '0;
        ro      = '0;
        re      = '0;
        age     = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            ra         = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            ro         = bus.rd_off[p*OFF_BITS +: OFF_BITS];
            re         = bus.rd_en[p*DW_B +: DW_B];
            rd_word[p] = mem[ra][ro] ^ {DW_B{8'(ra)}};
            for (int i = 0; i < int'(PEND_DEPTH); i++) begin
                // An entry is live when its distance from the head is below the count
                age = PTR_W'(i) - rd_ptr_q;
                if ((CNT_W'(age) < count_q) && collides(pend_q[i], re, ra, ro)) begin
                    hit[p] = 1'b1;
                end
            end
        end
    end

    // Storage writes; wb and the load path never target the same byte
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < int'(DW_B); j++) begin
                if (bus.wb_en[j]) begin
                    mem[bus.wb_addr][bus.wb_off][j] <= bus.wb_data[8*j +: 8] ^ 8'(bus.wb_addr);
                end
                if (ld_commit && commit_beat.en[j]) begin
                    mem[commit_beat.addr][commit_beat.off][j] <= commit_beat.data[j] ^ 8'(commit_beat.addr);
                end
            end
        end
    end

    // Registered read data and hazard flags, per-byte / per-port hold
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q   <= '0;
            rd_hazard_q <= '0;
        end else begin
            for (int p = 0; p < int'(NUM_RD); p++) begin
                for (int j = 0; j < int'(DW_B); j++) begin
                    if (bus.rd_en[p*DW_B + j]) begin
                        rd_data_q[p][j] <= rd_word[p][8*j +: 8];
                    end
                end
                if (bus.rd_en[p*DW_B +: DW_B] != '0) begin
                    rd_hazard_q[p] <= hit[p];
                end
            end
        end
    end

    // Pending load FIFO; ld_ready is registered from the next occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ld_ready_q <= 1'b1;
        end else begin
            if (do_push) begin
                pend_q[wr_ptr_q] <= ld_in;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q    <= count_next;
            ld_ready_q <= count_next < CNT_W'(PEND_DEPTH);
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_hazard  = rd_hazard_q;
    assign bus.ld_ready   = ld_ready_q;
    assign bus.pend_count = count_q;
endmodule

// File: doc/vec_regfile_mp.md
# vec_regfile_mp

Parametrised multi-port vector register file for the vector accelerator: `NUM_RD` independent byte-enabled read ports (operand and store reads) and two write ports (ALU writeback `wb`, memory load `ld`). A load beat that collides with a writeback to the same bytes is not dropped. Instead it is deferred into a small in-order pending-write buffer and committed once the collision clears, with backpressure to the load unit. Read ports report hazards against buffered loads.

## Interface
Parameters:
- `VLEN`, 128, bits per vector register.
- `ADDR_WIDTH`, 5, register index width (32 registers).
- `DATA_WIDTH`, 64, beat width. `VLEN` must be ≥ 2·`DATA_WIDTH` and a power-of-two multiple of it.
- `DW_B`, `DATA_WIDTH/8`, bytes per beat.
- `OFF_BITS`, `$clog2(VLEN/DATA_WIDTH)`, beat offset width.
- `NUM_RD`, 3, read ports. By convention, port `NUM_RD-1` is the store read port.
- `PEND_DEPTH`, 4, pending load-write entries (≥ 2, power of two).

Ports (flattened, port p at slice p):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_en` in `NUM_RD*DW_B`: per-port byte read enables.
- `rd_addr` in `NUM_RD*ADDR_WIDTH`: read register index.
- `rd_off` in `NUM_RD*OFF_BITS`: read beat offset.
- `rd_data` out `NUM_RD*DATA_WIDTH`: registered read data.
- `rd_hazard` out `NUM_RD`: registered flag, read overlapped a pending load.
- `wb_en` in `DW_B`: writeback byte enables (nonzero = write).
- `wb_addr` in `ADDR_WIDTH`, `wb_off` in `OFF_BITS`, `wb_data` in `DATA_WIDTH`: writeback beat.
- `ld_en` in `DW_B`: load byte enables (nonzero = request).
- `ld_addr` in `ADDR_WIDTH`, `ld_off` in `OFF_BITS`, `ld_data` in `DATA_WIDTH`: load beat.
- `ld_ready` out 1: load beat accepted this cycle when `|ld_en && ld_ready`.
- `pend_count` out `$clog2(PEND_DEPTH+1)`: occupied pending entries.

## Operation
- Storage: 2^`ADDR_WIDTH` × `VLEN/DATA_WIDTH` beats × `DW_B` bytes. Storage is not reset. At time zero every byte of register c holds c[7:0].
- Reads: for each port and byte j with `rd_en[j]`, `rd_data` byte j ← storage byte at the next edge. Bytes whose enable is clear hold their previous value. Reads are read-before-write: a same-cycle write is not visible until the following cycle.
- `rd_hazard[p]` ← 1 if, at the sampling edge, any valid pending entry matches `rd_addr`/`rd_off` with a byte mask overlapping `rd_en`. It is updated only when the port's `rd_en` is nonzero and otherwise holds.
- Collision: two beats collide when they have equal addr and off and their byte enables overlap.
- `wb` always commits its enabled bytes in the cycle presented. It has no stall.
- Buffer empty, load accepted:
  - no collision with `wb`: the load commits directly the same cycle. Disjoint bytes in the same beat commit together.
  - collision with `wb`: the whole load beat (data, enables, addr, off) is pushed to the buffer.
- Buffer non-empty: every accepted load is pushed, which preserves load order.
  - The head pops and commits through the load write path when it does not collide with the current `wb`. Otherwise it waits.
  - Push and pop in the same cycle are legal; `pend_count` is unchanged.
- Net effect: on a collision the load data wins, landing at least one cycle after the `wb`.
- `ld_ready` = `pend_count < PEND_DEPTH`, derived from registered state only. It does not depend on same-cycle inputs.
- The load source must hold the beat stable while `ld_ready` = 0.
- Pending FIFO uses wrap-around read/write pointers of width `$clog2(PEND_DEPTH)`.

## Timing
- Read latency: 1 cycle, address to `rd_data`/`rd_hazard`.
- Write visibility: `wb` or direct load data is readable by a read issued the next cycle.
- Deferred load: earliest commit is 1 cycle after the push, then one pop per cycle maximum.
- Reset (`rst` = 1 at an edge):
  - `rd_data` = 0, `rd_hazard` = 0, buffer flushed, `pend_count` = 0.
  - `ld_ready` = 1 from the first cycle after reset.
  - All writes are suppressed while `rst` is high; storage keeps its contents.
- Reset mid-operation discards pending load data. This is intended; the upstream units are reset with this block.
- Full: at `pend_count` = `PEND_DEPTH`, `ld_ready` = 0 even if a pop occurs that cycle. `ld_ready` returns to 1 the cycle after the first pop.

## Test plan
- Reset: hold `rst` for 2 cycles → `rd_data` = 0, `rd_hazard` = 0, `pend_count` = 0, `ld_ready` = 1; after reset, read v9 off1 all bytes → 0x0909090909090909.
- Writeback then read: `wb` v3 off1 data 0x1122334455667788, en 0xFF, with port 0 reading v3 off1 in the same cycle → old value (0x0303…03); repeat the read the next cycle → 0x1122334455667788.
- Partial enables: `wb` v3 off1 en 0x0F data 0xAAAAAAAAAAAAAAAA → subsequent read 0x11223344AAAAAAAA; a read with `rd_en` = 0x0F leaves the upper `rd_data` bytes unchanged.
- Disjoint same-cycle writes: `wb` v4 off0 en 0x0F data A, `ld` v4 off0 en 0xF0 data B → `pend_count` stays 0 and the next-cycle read shows B[63:32] and A[31:0].
- Collision deferral: `wb` v5 off0 en 0xFF data 0x1…1 with `ld` v5 off0 en 0xFF data 0x2…2 → `pend_count` = 1; a port 1 read of v5 off0 that cycle returns 0x1…1 with `rd_hazard` = 1; one cycle later v5 off0 = 0x2…2 and `pend_count` = 0.
- Backpressure and order: hold `wb` on v7 off0 (en 0xFF) while issuing loads to v7 off0 with data 1, 2, 3, 4, 5 → `ld_ready` drops after 4 accepted, load 5 is held; release `wb` → pops one per cycle in order, load 5 is accepted, final v7 off0 = 5; asserting `rst` midway → `pend_count` = 0 next cycle.
